// File: rtl/mem_addr_gen_scroll.sv
// mem_addr_gen_scroll: framebuffer address generator for the VGA path.
// Maps 640x480 display counters to a downscaled SRC_W x SRC_H source
// image and adds a per-frame 2-D wrapping scroll. Two registered stages,
// so the latency is exactly 2 clk and the throughput is one address per clk.
// Optional build macro: MEM_ADDR_MIRROR_EN adds an hflip input that
// mirrors the source column after the wrap.
module mem_addr_gen_scroll #(
  parameter int unsigned SRC_W       = 320,
  parameter int unsigned SRC_H       = 240,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned STEP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_start,
  input  logic [1:0]        mode,
  input  logic              pause,
`ifdef MEM_ADDR_MIRROR_EN
  input  logic              hflip,
`endif
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              addr_valid
);

  // Coordinate widths hold SRC_x-1+STEP; the sums carry one extra bit
  // because source coordinate plus offset can reach 2*SRC_x-2.
  localparam int unsigned XW = $clog2(SRC_W + STEP);
  localparam int unsigned YW = $clog2(SRC_H + STEP);

  localparam logic [XW:0]   SRC_W_S  = (XW+1)'(SRC_W);
  localparam logic [YW:0]   SRC_H_S  = (YW+1)'(SRC_H);
  localparam logic [XW:0]   STEP_X   = (XW+1)'(STEP);
  localparam logic [YW:0]   STEP_Y   = (YW+1)'(STEP);
  localparam logic [XW-1:0] X_MAX    = XW'(SRC_W - 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(SRC_W);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_UP     = 2'd1,
    MODE_LEFT   = 2'd2,
    MODE_DIAG   = 2'd3
  } scroll_mode_e;

  scroll_mode_e mode_in;
  assign mode_in = scroll_mode_e'(mode);

  // Scroll offsets (always below their bounds)
  logic [XW-1:0] off_x_q, off_x_d;
  logic [YW-1:0] off_y_q, off_y_d;

  // Stage 1 registers
  logic          active_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  // Stage 2 registers
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;

  // Stage 1 combinational values
  logic          active_d;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic [XW-1:0] x_wrap;
  logic [YW-1:0] y_wrap;
  logic [XW-1:0] x_d;

  // Offset advance candidates
  logic [XW:0]   off_x_sum;
  logic [YW:0]   off_y_sum;
  logic [XW-1:0] off_x_adv;
  logic [YW-1:0] off_y_adv;
  logic          adv_x;
  logic          adv_y;

  // Stage 2 combinational value
  logic [ADDR_W-1:0] addr_d;

  // Display-to-source mapping with a single conditional wrap per axis
  always_comb begin
    active_d = (h_cnt < 10'd640) && (v_cnt < 10'd480);
    // Blanking coordinates may truncate here; they are masked by active.
    sx       = XW'(h_cnt >> SCALE_SHIFT);
    sy       = YW'(v_cnt >> SCALE_SHIFT);
    x_sum    = {1'b0, sx} + {1'b0, off_x_q};
    y_sum    = {1'b0, sy} + {1'b0, off_y_q};
    x_wrap   = (x_sum >= SRC_W_S) ? XW'(x_sum - SRC_W_S) : XW'(x_sum);
    y_wrap   = (y_sum >= SRC_H_S) ? YW'(y_sum - SRC_H_S) : YW'(y_sum);
`ifdef MEM_ADDR_MIRROR_EN
    x_d      = hflip ? (X_MAX - x_wrap) : x_wrap;
`else
    x_d      = x_wrap;
`endif
  end

  // Next offsets: the incoming mode decides which axes advance this frame
  always_comb begin
    off_x_sum = {1'b0, off_x_q} + STEP_X;
    off_y_sum = {1'b0, off_y_q} + STEP_Y;
    off_x_adv = (off_x_sum >= SRC_W_S) ? XW'(off_x_sum - SRC_W_S) : XW'(off_x_sum);
    off_y_adv = (off_y_sum >= SRC_H_S) ? YW'(off_y_sum - SRC_H_S) : YW'(off_y_sum);
    adv_x     = 1'b0;
    adv_y     = 1'b0;
    case (mode_in)
      MODE_UP:   adv_y = 1'b1;
      MODE_LEFT: adv_x = 1'b1;
      MODE_DIAG: begin
        adv_x = 1'b1;
        adv_y = 1'b1;
      end
      default: ;
    endcase
    off_x_d = off_x_q;
    off_y_d = off_y_q;
    if (frame_start && !pause) begin
      if (adv_x) off_x_d = off_x_adv;
      if (adv_y) off_y_d = off_y_adv;
    end
  end

  // Linear address from the stage-1 coordinates
  always_comb begin
    addr_d = active_q ? (ADDR_W'(y_q) * ROW_PITCH + ADDR_W'(x_q)) : '0;
  end

  // Scroll offset state; only frame_start edges can change it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_x_q <= '0;
      off_y_q <= '0;
    end else begin
      off_x_q <= off_x_d;
      off_y_q <= off_y_d;
    end
  end

  // Stage 1: capture active flag and wrapped source coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_wrap;
    end
  end

  // Stage 2: register the address and its valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= active_q;
    end
  end

  assign pixel_addr = addr_q;
  assign addr_valid = valid_q;

endmodule
